// File: rtl/pcrel_pipe.sv
// -----------------------------------------------------------------------------
// pcrel_pipe
//
// Pipelined PC-relative execution unit. Resolves AUIPC, JAL, JALR and
// conditional branches for an XLEN-wide core, then carries the result
// through STAGES register stages to the writeback/redirect logic.
//
// Parameters
//   XLEN     datapath width (32 or 64)
//   STAGES   register stages from input to output (1..4)
//   ALLOW_C  1: compressed ops legal, 2-byte target granule
//            0: compressed ops illegal, 4-byte target granule
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every in-flight op and any op accepted this cycle
//   in_valid/in_ready input handshake
//   in_op             0=AUIPC 1=JAL 2=JALR 3=BRANCH
//   in_funct3         branch condition
//   in_compressed     instruction is 16-bit
//   in_pc, in_imm     instruction address, sign-extended immediate
//   in_rs1, in_rs2    source operand values
//   in_rd             destination register index
//   out_valid/out_ready output handshake
//   out_rd_idx/we/val register writeback
//   out_br_valid/out_br_target redirect request
//   out_exc_misalign  taken target not on the instruction granule
//   out_exc_illegal   illegal encoding
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready. While out_valid && !out_ready every out_*
// signal holds. in_ready is combinational from out_ready through the full
// stage chain, so a full pipeline that drains at the output accepts a new op
// in the same cycle (no bubble).
// -----------------------------------------------------------------------------
module pcrel_pipe #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 1,
  parameter int ALLOW_C = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_compressed,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd_idx,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_rd_val,
  output logic            out_br_valid,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_exc_misalign,
  output logic            out_exc_illegal
);

  localparam logic [1:0] OP_AUIPC  = 2'd0;
  localparam logic [1:0] OP_JAL    = 2'd1;
  localparam logic [1:0] OP_JALR   = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  // One resolved op as it travels down the pipeline.
  typedef struct packed {
    logic [4:0]      rd_idx;
    logic            rd_we;
    logic [XLEN-1:0] rd_val;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            exc_misalign;
    logic            exc_illegal;
  } res_t;

  // ---------------------------------------------------------------------------
  // Combinational resolve of the op currently presented at the input
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rel;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] rd_val_c;
  logic            is_eq;
  logic            is_lt_s;
  logic            is_lt_u;
  logic            br_cond;
  logic            take;
  logic            illegal;
  logic            bad_align;
  logic            misalign;
  res_t            res_c;

  always_comb begin
    rel      = in_pc + in_imm;
    link     = in_pc + (in_compressed ? XLEN'(2) : XLEN'(4));
    jalr_sum = in_rs1 + in_imm;

    is_eq   = (in_rs1 == in_rs2);
    is_lt_s = ($signed(in_rs1) < $signed(in_rs2));
    is_lt_u = (in_rs1 < in_rs2);

    // funct3 010/011 are reserved; they resolve not-taken and are flagged
    // illegal below, so the default arm is never a real redirect.
    case (in_funct3)
      3'b000:  br_cond = is_eq;
      3'b001:  br_cond = !is_eq;
      3'b100:  br_cond = is_lt_s;
      3'b101:  br_cond = !is_lt_s;
      3'b110:  br_cond = is_lt_u;
      3'b111:  br_cond = !is_lt_u;
      default: br_cond = 1'b0;
    endcase

    rd_val_c = '0;
    target   = '0;
    take     = 1'b0;
    case (in_op)
      OP_AUIPC: begin
        rd_val_c = rel;
      end
      OP_JAL: begin
        rd_val_c = link;
        target   = rel;
        take     = 1'b1;
      end
      OP_JALR: begin
        rd_val_c = link;
        target   = jalr_sum & ~XLEN'(1);
        take     = 1'b1;
      end
      default: begin
        target   = rel;
        take     = br_cond;
      end
    endcase

    illegal = ((in_op == OP_BRANCH) &&
               ((in_funct3 == 3'b010) || (in_funct3 == 3'b011))) ||
              (in_compressed && (ALLOW_C == 0));

    // With compressed support the granule is 2 bytes; JALR clears bit 0, so
    // it can only trip this check when the granule is 4 bytes.
    bad_align = (ALLOW_C != 0) ? target[0] : (target[1:0] != 2'b00);
    misalign  = take && bad_align && !illegal;

    res_c.rd_idx       = in_rd;
    res_c.rd_we        = (in_op != OP_BRANCH) && (in_rd != 5'd0) &&
                         !illegal && !misalign;
    res_c.rd_val       = rd_val_c;
    res_c.br_valid     = take && !illegal && !misalign;
    res_c.br_target    = target;
    res_c.exc_misalign = misalign;
    res_c.exc_illegal  = illegal;
  end

  // ---------------------------------------------------------------------------
  // Stage chain
  // ---------------------------------------------------------------------------
  res_t              st_data  [STAGES];
  res_t              src_data [STAGES];
  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] st_ready;

  // A stage can take new contents when it is empty or when its own contents
  // move on this cycle. Computed from the output back to the input so a full
  // pipe advances as a whole whenever the consumer is ready.
  always_comb begin
    st_ready = '0;
    st_ready[STAGES-1] = !st_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      st_ready[k] = !st_valid[k] || st_ready[k+1];
    end
  end

  // Source feeding each stage: the resolver for stage 0, the previous stage
  // otherwise.
  always_comb begin
    src_data[0]  = res_c;
    src_valid    = '0;
    src_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_data[k]  = st_data[k-1];
      src_valid[k] = st_valid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        // Flush wins over any load, including the op accepted this cycle.
        if (flush) begin
          st_valid[k] <= 1'b0;
        end else if (st_ready[k]) begin
          st_valid[k] <= src_valid[k];
        end
        // Data only moves with a valid source, so a stalled or emptied stage
        // keeps its last contents on the outputs.
        if (st_ready[k] && src_valid[k]) begin
          st_data[k] <= src_data[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready         = st_ready[0];
  assign out_valid        = st_valid[STAGES-1];
  assign out_rd_idx       = st_data[STAGES-1].rd_idx;
  assign out_rd_we        = st_data[STAGES-1].rd_we;
  assign out_rd_val       = st_data[STAGES-1].rd_val;
  assign out_br_valid     = st_data[STAGES-1].br_valid;
  assign out_br_target    = st_data[STAGES-1].br_target;
  assign out_exc_misalign = st_data[STAGES-1].exc_misalign;
  assign out_exc_illegal  = st_data[STAGES-1].exc_illegal;

endmodule

// File: tb/tb_pcrel_pipe.sv
// -----------------------------------------------------------------------------
// tb_pcrel_pipe
//
// Two instances share one set of input signals: dut_a (STAGES=1, ALLOW_C=0)
// and dut_b (STAGES=3, ALLOW_C=1). 'sel' picks which instance sees in_valid
// and out_ready and whose outputs are observed; the other one idles.
// -----------------------------------------------------------------------------
module tb_pcrel_pipe;

  localparam int RW = 73;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        c;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic        we;
    logic [31:0] val;
    logic        br;
    logic [31:0] tgt;
    logic        mis;
    logic        ill;
  } res_t;

  typedef struct {
    in_t  x;
    res_t e;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Clock / reset / shared stimulus signals
  // ---------------------------------------------------------------------------
  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic flush    = 1'b0;
  logic tb_valid = 1'b0;
  logic tb_ready = 1'b0;
  logic sel      = 1'b0;
  in_t  din      = '0;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_rd_we, a_br_valid, a_mis, a_ill;
  logic [4:0]  a_rd_idx;
  logic [31:0] a_rd_val, a_br_target;
  logic        b_in_ready, b_out_valid, b_rd_we, b_br_valid, b_mis, b_ill;
  logic [4:0]  b_rd_idx;
  logic [31:0] b_rd_val, b_br_target;

  pcrel_pipe #(.XLEN(32), .STAGES(1), .ALLOW_C(0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(tb_valid && !sel), .in_ready(a_in_ready),
    .in_op(din.op), .in_funct3(din.f3), .in_compressed(din.c),
    .in_pc(din.pc), .in_imm(din.imm), .in_rs1(din.rs1), .in_rs2(din.rs2),
    .in_rd(din.rd),
    .out_valid(a_out_valid), .out_ready(tb_ready && !sel),
    .out_rd_idx(a_rd_idx), .out_rd_we(a_rd_we), .out_rd_val(a_rd_val),
    .out_br_valid(a_br_valid), .out_br_target(a_br_target),
    .out_exc_misalign(a_mis), .out_exc_illegal(a_ill)
  );

  pcrel_pipe #(.XLEN(32), .STAGES(3), .ALLOW_C(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(tb_valid && sel), .in_ready(b_in_ready),
    .in_op(din.op), .in_funct3(din.f3), .in_compressed(din.c),
    .in_pc(din.pc), .in_imm(din.imm), .in_rs1(din.rs1), .in_rs2(din.rs2),
    .in_rd(din.rd),
    .out_valid(b_out_valid), .out_ready(tb_ready && sel),
    .out_rd_idx(b_rd_idx), .out_rd_we(b_rd_we), .out_rd_val(b_rd_val),
    .out_br_valid(b_br_valid), .out_br_target(b_br_target),
    .out_exc_misalign(b_mis), .out_exc_illegal(b_ill)
  );

  logic o_valid, o_in_ready;
  res_t o_res;
  assign o_valid    = sel ? b_out_valid : a_out_valid;
  assign o_in_ready = sel ? b_in_ready : a_in_ready;
  assign o_res = sel ? {b_rd_idx, b_rd_we, b_rd_val, b_br_valid, b_br_target, b_mis, b_ill}
                     : {a_rd_idx, a_rd_we, a_rd_val, a_br_valid, a_br_target, a_mis, a_ill};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total  = 0;
  int bad    = 0;
  int popped = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: straight from the instruction semantics.
  function automatic res_t model(input in_t x, input bit allow_c);
    res_t r;
    logic [31:0] rel, link, sum, tgt, val;
    bit take, ill, mis;
    int gran;
    rel  = x.pc + x.imm;
    link = x.pc + (x.c ? 32'd2 : 32'd4);
    gran = allow_c ? 2 : 4;
    ill  = (x.c && !allow_c) || (x.op == 2'd3 && (x.f3 == 3'd2 || x.f3 == 3'd3));
    take = 0;
    val  = 0;
    tgt  = 0;
    case (x.op)
      2'd0: val = rel;
      2'd1: begin val = link; tgt = rel; take = 1; end
      2'd2: begin val = link; sum = x.rs1 + x.imm; tgt = sum - (sum % 2); take = 1; end
      default: begin
        tgt = rel;
        case (x.f3)
          3'd0: take = (x.rs1 == x.rs2);
          3'd1: take = (x.rs1 != x.rs2);
          3'd4: take = (int'(x.rs1) <  int'(x.rs2));
          3'd5: take = (int'(x.rs1) >= int'(x.rs2));
          3'd6: take = (x.rs1 <  x.rs2);
          3'd7: take = (x.rs1 >= x.rs2);
          default: take = 0;
        endcase
      end
    endcase
    mis   = !ill && take && ((tgt % gran) != 0);
    r.idx = x.rd;
    r.we  = (x.op != 2'd3) && (x.rd != 0) && !ill && !mis;
    r.val = val;
    r.br  = take && !ill && !mis;
    r.tgt = tgt;
    r.mis = mis;
    r.ill = ill;
    return r;
  endfunction

  function automatic in_t mk_in(input logic [1:0] op, input logic [2:0] f3, input logic c,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [4:0] rd);
    in_t x;
    x.op = op; x.f3 = f3; x.c = c; x.pc = pc; x.imm = imm;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    return x;
  endfunction

  function automatic res_t mk_res(input logic [4:0] idx, input logic we, input logic [31:0] val,
                                  input logic br, input logic [31:0] tgt,
                                  input logic mis, input logic ill);
    res_t r;
    r.idx = idx; r.we = we; r.val = val; r.br = br; r.tgt = tgt; r.mis = mis; r.ill = ill;
    return r;
  endfunction

  function automatic logic [31:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.op  = 2'($urandom_range(0, 3));
    x.f3  = 3'($urandom_range(0, 7));
    x.c   = ($urandom_range(0, 3) == 0);
    x.pc  = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
    x.imm = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 511)) - 32'd256);
    x.rs1 = pick_reg();
    x.rs2 = pick_reg();
    x.rd  = 5'($urandom_range(0, 31));
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle, called right after a falling edge
  // ---------------------------------------------------------------------------
  task automatic tick(input logic v, input in_t x, input logic ordy, input logic fl,
                      output logic acc);
    logic [RW-1:0] e;
    int depth;
    tb_valid = v;
    din      = x;
    tb_ready = ordy;
    flush    = fl;
    #1;
    depth = sel ? 3 : 1;
    // Bubble-free chain: only a completely full, stalled pipe refuses input.
    chk("in_ready", o_in_ready, (exp_q.size() < depth) || ordy);
    if (o_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", o_res, '0 - 1);
      end else begin
        e = exp_q.pop_front();
        chk("result", o_res, e);
        popped++;
      end
    end
    acc = v && o_in_ready;
    if (acc && !fl) exp_q.push_back(model(x, sel));
    if (fl) exp_q.delete();
    @(negedge clk);
    tb_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick(0, '0, 1, 0, acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t tbl[14];
  in_t  ops[5];

  initial begin
    logic acc;
    int n_acc, cyc, p0;
    in_t x;

    tbl[0]  = '{x: mk_in(1, 0, 0, 32'h1000, 32'h20, 0, 0, 1),
                e: mk_res(1, 1, 32'h1004, 1, 32'h1020, 0, 0)};
    tbl[1]  = '{x: mk_in(3, 5, 0, 32'h2000, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0),
                e: mk_res(0, 0, 0, 1, 32'h2010, 0, 0)};
    tbl[2]  = '{x: mk_in(3, 4, 0, 32'h2004, 32'hFFFFFFF8, 32'hFFFFFFFF, 1, 0),
                e: mk_res(0, 0, 0, 1, 32'h1FFC, 0, 0)};
    tbl[3]  = '{x: mk_in(3, 7, 0, 32'h2008, 32'h8, 1, 32'hFFFFFFFF, 0),
                e: mk_res(0, 0, 0, 0, 32'h2010, 0, 0)};
    tbl[4]  = '{x: mk_in(2, 0, 0, 32'h3000, 0, 32'h1002, 0, 2),
                e: mk_res(2, 0, 32'h3004, 0, 32'h1002, 1, 0)};
    tbl[5]  = '{x: mk_in(3, 2, 0, 32'h4000, 32'h4, 0, 0, 5),
                e: mk_res(5, 0, 0, 0, 32'h4004, 0, 1)};
    tbl[6]  = '{x: mk_in(0, 0, 0, 32'hFFFFFFF0, 32'h20, 0, 0, 3),
                e: mk_res(3, 1, 32'h10, 0, 0, 0, 0)};
    tbl[7]  = '{x: mk_in(1, 0, 1, 32'h5000, 32'h100, 0, 0, 1),
                e: mk_res(1, 0, 32'h5002, 0, 32'h5100, 0, 1)};
    tbl[8]  = '{x: mk_in(3, 0, 0, 32'h6000, 32'h6, 7, 7, 0),
                e: mk_res(0, 0, 0, 0, 32'h6006, 1, 0)};
    tbl[9]  = '{x: mk_in(3, 1, 0, 32'h100, 32'hFFFFFF00, 1, 2, 0),
                e: mk_res(0, 0, 0, 1, 32'h0, 0, 0)};
    tbl[10] = '{x: mk_in(1, 0, 0, 32'hFFFFFFFC, 32'h8, 0, 0, 0),
                e: mk_res(0, 0, 32'h0, 1, 32'h4, 0, 0)};
    tbl[11] = '{x: mk_in(3, 6, 0, 32'h7000, 32'h40, 1, 32'hFFFFFFFF, 0),
                e: mk_res(0, 0, 0, 1, 32'h7040, 0, 0)};
    tbl[12] = '{x: mk_in(3, 3, 0, 32'h7100, 32'h8, 0, 0, 4),
                e: mk_res(4, 0, 0, 0, 32'h7108, 0, 1)};
    tbl[13] = '{x: mk_in(2, 0, 0, 32'h8000, 32'h4, 32'h2001, 0, 7),
                e: mk_res(7, 1, 32'h8004, 1, 32'h2004, 0, 0)};

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    #1;
    chk("reset_a_out", {o_valid, o_res}, '0);
    chk("reset_a_in_ready", o_in_ready, 1);
    sel = 1'b1;
    #1;
    chk("reset_b_out", {o_valid, o_res}, '0);
    chk("reset_b_in_ready", o_in_ready, 1);
    @(negedge clk);

    // Directed vectors, back to back, on the single-stage 4-byte-granule unit
    sel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1, tbl[i].x, 1, 0, acc);
      chk($sformatf("tbl%0d", i), {o_valid, o_res}, {1'b1, tbl[i].e});
    end
    drain();

    // Three-stage latency, compressed JALR with 2-byte granule
    sel = 1'b1;
    x = mk_in(2, 0, 1, 32'h3000, 0, 32'h1002, 0, 2);
    tick(1, x, 1, 0, acc);
    chk("lat_cycle1", o_valid, 0);
    tick(0, '0, 1, 0, acc);
    chk("lat_cycle2", o_valid, 0);
    tick(0, '0, 1, 0, acc);
    chk("lat_cycle3", {o_valid, o_res}, {1'b1, mk_res(2, 1, 32'h3002, 1, 32'h1002, 0, 0)});
    drain();

    // Backpressure: five ops against a stalled consumer
    popped = 0;
    for (int i = 0; i < 5; i++) ops[i] = rand_in();
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 3 && cyc < 20) begin
      tick(1, ops[n_acc], 0, 0, acc);
      if (acc) n_acc++;
      cyc++;
    end
    chk("fill_cycles", cyc, 3);
    for (int i = 0; i < 4; i++) begin
      tick(1, ops[3], 0, 0, acc);
      chk("stall_no_accept", acc, 0);
      chk("stall_hold", {o_valid, o_res}, {1'b1, model(ops[0], 1)});
    end
    cyc = 0;
    while ((n_acc < 5 || exp_q.size() > 0) && cyc < 40) begin
      tick(n_acc < 5, ops[(n_acc < 5) ? n_acc : 0], 1, 0, acc);
      if (acc) n_acc++;
      cyc++;
    end
    chk("stall_all_out", popped, 5);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Flush with two in flight plus one accepted in the flush cycle
    p0 = popped;
    tick(1, rand_in(), 0, 0, acc);
    tick(1, rand_in(), 0, 0, acc);
    tick(1, rand_in(), 0, 1, acc);
    chk("flush_same_cycle_accept", acc, 1);
    chk("flush_out_valid", o_valid, 0);
    for (int i = 0; i < 6; i++) tick(0, '0, 1, 0, acc);
    chk("flush_none_emerge", popped, p0);

    // Reset with ops in flight
    tick(1, rand_in(), 0, 0, acc);
    tick(1, rand_in(), 0, 0, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_out", {o_valid, o_res}, '0);
    chk("midreset_in_ready", o_in_ready, 1);
    p0 = popped;
    for (int i = 0; i < 5; i++) tick(0, '0, 1, 0, acc);
    chk("midreset_none_emerge", popped, p0);

    // Random traffic on both configurations
    for (int s = 1; s >= 0; s--) begin
      sel = (s == 1);
      for (int i = 0; i < 400; i++) begin
        tick($urandom_range(0, 9) < 7, rand_in(), $urandom_range(0, 9) < 7,
             $urandom_range(0, 39) == 0, acc);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcrel_pipe.md
Name: pcrel_pipe

Overview:
Parametrised successor to the combinational PC-relative execution unit. It resolves AUIPC, JAL, JALR and conditional branches for XLEN-wide cores, with optional C-extension link/alignment rules and a configurable pipeline depth. It has full valid/ready handshaking on both sides and flush support. It sits in the exec stage between issue and the writeback/redirect logic.

Parameters:
XLEN, 32, datapath width (32 or 64)
STAGES, 1, pipeline register stages from input to output (1..4)
ALLOW_C, 1, 1 = compressed instructions legal, alignment granule 2 bytes; 0 = 4 bytes

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  kill all in-flight and same-cycle-accepted ops
in_valid  input  1  op presented
in_ready  output  1  op accepted when in_valid&&in_ready
in_op  input  2  0=AUIPC 1=JAL 2=JALR 3=BRANCH
in_funct3  input  3  branch condition
in_compressed  input  1  instruction is 16-bit
in_pc  input  XLEN  instruction address
in_imm  input  XLEN  sign-extended immediate
in_rs1  input  XLEN  rs1 value
in_rs2  input  XLEN  rs2 value
in_rd  input  5  destination index
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_rd_idx  output  5  destination index
out_rd_we  output  1  write rd
out_rd_val  output  XLEN  rd value
out_br_valid  output  1  redirect to out_br_target
out_br_target  output  XLEN  redirect target
out_exc_misalign  output  1  taken target misaligned
out_exc_illegal  output  1  illegal encoding

Behaviour:
- Reset: all stage valids cleared. out_valid=0. All out_* data=0. in_ready=1 in the first cycle after reset deasserts.
- Compute, combinational on inputs, captured into stage 0:
  - rel = in_pc + in_imm (mod 2^XLEN)
  - link = in_pc + (in_compressed ? 2 : 4)
  - AUIPC: rd_val=rel, br_valid=0
  - JAL: rd_val=link, target=rel, br_valid=1
  - JALR: rd_val=link, target=(in_rs1+in_imm) with bit0 cleared, br_valid=1
  - BRANCH: target=rel, rd_we=0, rd_val=0. funct3 conditions:
    - 000 EQ, 001 NE
    - 100 signed LT, 101 signed GE (>=, equality taken)
    - 110 unsigned LT, 111 unsigned GE (>=)
  - AUIPC: out_br_target=0.
- Illegal (out_exc_illegal=1) when any of:
  - BRANCH with funct3 010 or 011
  - in_compressed with ALLOW_C=0
  - in_compressed with op AUIPC or BRANCH is legal; no other restriction
- Misalign (out_exc_misalign=1) only when br_valid would be 1 and either:
  - ALLOW_C=0 and target[1:0]!=0, or
  - ALLOW_C=1 and target[0]!=0 (unreachable for JALR).
- Any exception forces out_br_valid=0 and out_rd_we=0. Illegal takes priority; misalign=0 when illegal=1.
- out_rd_we = (op!=BRANCH) && rd!=0 && no exception.
- Pipeline: STAGES registers, each with a valid bit.
  - Stage k loads from k-1 when stage k is empty or advancing.
  - Last stage advances when out_ready.
  - out_* = last stage contents; out_valid = last-stage valid.
  - in_ready = !v0 || stage0 advancing (the full ready chain, no bubble).
- Latency: STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, all out_* hold stable. The pipeline fills to STAGES ops, then in_ready=0.
- Flush: all valids cleared at the next edge. An op handshaken in the flush cycle is dropped. A result handshaken in the flush cycle (out_valid&&out_ready) counts as consumed. Flush has priority over load. If rst and flush are both asserted, rst wins (same outcome).
- Reset mid-operation: all in-flight ops are discarded, with no output handshake.
- Wrap-around: pc near 2^XLEN wraps modulo 2^XLEN and is not flagged.

Test Plan:
- XLEN=32, STAGES=1: JAL pc=0x1000 imm=0x20 rd=1 -> next cycle out_br_valid=1, target=0x1020, rd_val=0x1004, rd_we=1.
- BGE rs1=rs2=0xFFFFFFFF, then BLT rs1=0xFFFFFFFF rs2=1, then BGEU rs1=1 rs2=0xFFFFFFFF -> br_valid=1, 1, 0 in consecutive cycles.
- ALLOW_C=0: JALR rs1=0x1002 imm=0 -> exc_misalign=1, br_valid=0, rd_we=0. ALLOW_C=1, same op, compressed -> br_valid=1, target=0x1002, rd_val=pc+2.
- STAGES=3: issue 5 back-to-back ops with out_ready=0 -> in_ready drops after the 3rd acceptance and out_* stay stable. Release out_ready -> results come out in order, one per cycle, with none lost or duplicated.
- Flush with 2 ops in flight plus one accepted the same cycle -> out_valid=0 next cycle and none of the 3 ops ever emerge.
- BRANCH funct3=010 with rd=5 -> exc_illegal=1, br_valid=0, rd_we=0. AUIPC pc=0xFFFFFFF0 imm=0x20 -> rd_val=0x10.
